uart_rx_byte_sorter: RTL and testbench
======================================

Name: uart_rx_byte_sorter

Overview:
- Sits directly downstream of the UART receiver. Consumes its one-cycle data-valid pulse and received byte.
- Collects a frame of DEPTH bytes into an internal buffer and sorts the buffer in place with a one-compare-per-cycle bubble-sort FSM.
- Streams the sorted frame out on a valid/ready byte interface toward the transmit side.

Parameters:
- DEPTH, 8, number of bytes per frame; legal range 2..16.
- DATA_W, 8, width of each byte; must match the receiver byte width.

Ports:
- i_clock  in  1  single system clock; all logic is on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_Rx_DV  in  1  one-cycle pulse from the UART receiver: byte valid.
- i_Rx_Byte  in  DATA_W  received byte; sampled only when i_Rx_DV=1.
- i_Tx_Ready  in  1  downstream accepts the byte when o_Tx_DV=1 and i_Tx_Ready=1.
- o_Tx_DV  out  1  sorted byte valid.
- o_Tx_Byte  out  DATA_W  sorted byte.
- o_Busy  out  1  high in S_SORT and S_OUT.
- o_Done  out  1  one-cycle pulse after the last byte of a frame is accepted.
- o_Drop  out  1  one-cycle pulse when an input byte is discarded.

Behaviour:
- Reset (asynchronous, active-low):
  - state=S_FILL; fill count, sort indices, swap flag and output index cleared; buffer cleared to 0.
  - Outputs: o_Tx_DV=0, o_Tx_Byte=0, o_Busy=0, o_Done=0, o_Drop=0.
  - Reset asserted mid-frame aborts the frame with no output. The next frame starts at index 0.
- S_FILL:
  - On i_Rx_DV, write buf[count]<=i_Rx_Byte and count<=count+1.
  - The cycle the DEPTH-th byte is written, state<=S_SORT, j<=0, limit<=DEPTH-1, swapped<=0.
  - No timeout: a partial frame waits indefinitely.
- S_SORT (one compare per cycle):
  - Compare buf[j] and buf[j+1]. Swap if buf[j] > buf[j+1] (unsigned) and set swapped.
  - Equal values never swap, so the sort is stable.
  - If j < limit-1: j<=j+1.
  - If j = limit-1 (end of pass):
    - If no swap occurred anywhere in this pass, including this cycle, or limit=1: state<=S_OUT, k<=0.
    - Otherwise: limit<=limit-1, j<=0, swapped<=0.
  - Worst case for DEPTH=8: 28 compare cycles. Already-sorted frame: 7 cycles.
- S_OUT:
  - o_Tx_DV=1 and o_Tx_Byte=buf[k] from the first cycle in S_OUT.
  - Both held stable while i_Tx_Ready=0.
  - On accept, k<=k+1 and o_Tx_Byte updates to the next byte in the same registered step, giving back-to-back bytes when i_Tx_Ready is held high.
  - On accept of k=DEPTH-1:
    - Next cycle: o_Tx_DV=0, o_Done=1 for one cycle, state<=S_FILL, count<=0.
- Drop rule:
  - i_Rx_DV in S_SORT or S_OUT: byte discarded, buffer untouched, o_Drop=1 the following cycle.
  - i_Rx_DV in the cycle the frame returns to S_FILL (the o_Done cycle) is accepted as byte 0 of the next frame.
- Width rules: counters are clog2(DEPTH)+1 bits. No arithmetic on data beyond the comparison.

Optional Feature:
- Macro: UART_SORTER_DESCENDING_EN
- Defined: the compare becomes buf[j] < buf[j+1], so output is in descending order. All timing and early-exit rules are unchanged.
- Undefined: ascending order as specified above.

Test Plan:
- Feed 0x07,0x06,...,0x00 with i_Tx_Ready=1 -> exactly 28 cycles in S_SORT; output 0x00..0x07 on 8 consecutive cycles; o_Done pulses once.
- Feed 0x10..0x17 in order -> 7 cycles in S_SORT (early exit); output 0x10..0x17 unchanged.
- Feed 5,3,5,1,3,1,0,9 -> output 0,1,1,3,3,5,5,9; no spurious o_Drop.
- Hold i_Tx_Ready=0 for 5 cycles after the 3rd output byte -> o_Tx_DV stays high; o_Tx_Byte holds the 4th sorted value; no byte lost or repeated.
- Pulse i_Rx_DV=0xAA during S_SORT -> o_Drop=1 for one cycle; 0xAA never appears in the output. Then assert i_rst_n=0 mid-S_OUT -> o_Tx_DV=0 immediately; the following frame sorts correctly from index 0.
- With UART_SORTER_DESCENDING_EN defined, feed 0x00..0x07 -> output 0x07..0x00 after 28 sort cycles.

Source files
------------

// File: rtl/uart_rx_byte_sorter_if.sv
// -----------------------------------------------------------------------------
// uart_rx_byte_sorter_if
// Bundles the byte-level signals around the frame sorter.
//   i_Rx_DV / i_Rx_Byte : receiver byte strobe and data (toward the sorter)
//   i_Tx_Ready          : downstream ready (toward the sorter)
//   o_Tx_DV / o_Tx_Byte : sorted byte stream (from the sorter)
//   o_Busy / o_Done / o_Drop : status (from the sorter)
// Modports:
//   master : the environment (receiver + transmit side) driving the sorter
//   slave  : the sorter itself
// -----------------------------------------------------------------------------
interface uart_rx_byte_sorter_if #(
   parameter int DATA_W = 8
);
   logic              i_Rx_DV;
   logic [DATA_W-1:0] i_Rx_Byte;
   logic              i_Tx_Ready;
   logic              o_Tx_DV;
   logic [DATA_W-1:0] o_Tx_Byte;
   logic              o_Busy;
   logic              o_Done;
   logic              o_Drop;

   modport master (
      output i_Rx_DV, i_Rx_Byte, i_Tx_Ready,
      input  o_Tx_DV, o_Tx_Byte, o_Busy, o_Done, o_Drop
   );

   modport slave (
      input  i_Rx_DV, i_Rx_Byte, i_Tx_Ready,
      output o_Tx_DV, o_Tx_Byte, o_Busy, o_Done, o_Drop
   );
endinterface

// File: rtl/uart_rx_byte_sorter.sv
// -----------------------------------------------------------------------------
// uart_rx_byte_sorter
// Collects DEPTH bytes from the UART receiver, bubble-sorts them in place with
// one compare per clock, then streams the sorted frame out on a valid/ready
// byte interface.
//
// Ports:
//   i_clock : system clock (rising edge)
//   i_rst_n : asynchronous active-low reset
//   bus     : uart_rx_byte_sorter_if.slave
//             in : i_Rx_DV, i_Rx_Byte, i_Tx_Ready
//             out: o_Tx_DV, o_Tx_Byte, o_Busy, o_Done, o_Drop
//
// Parameters:
//   DEPTH  : bytes per frame (2..16)
//   DATA_W : byte width
//
// Build option:
//   UART_SORTER_DESCENDING_EN : when defined the frame is emitted in
//                               descending order instead of ascending.
// -----------------------------------------------------------------------------
module uart_rx_byte_sorter #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8
) (
   input  logic                  i_clock,
   input  logic                  i_rst_n,
   uart_rx_byte_sorter_if.slave  bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_SORT = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   j_q, j_d;
   logic [CNT_W-1:0]   limit_q, limit_d;
   logic               swapped_q, swapped_d;
   logic [CNT_W-1:0]   k_q, k_d;
   logic               tx_dv_q, tx_dv_d;
   logic [DATA_W-1:0]  tx_byte_q, tx_byte_d;
   logic               done_q, done_d;
   logic               drop_q, drop_d;
   logic [DATA_W-1:0]  mem_q [DEPTH];
   logic [DATA_W-1:0]  mem_d [DEPTH];

   logic [CNT_W-1:0]   j_p1;
   logic [DATA_W-1:0]  cmp_lo;
   logic [DATA_W-1:0]  cmp_hi;
   logic               do_swap;
   logic               pass_swapped;

   assign j_p1   = j_q + ONE;
   assign cmp_lo = mem_q[j_q[IDX_W-1:0]];
   assign cmp_hi = mem_q[j_p1[IDX_W-1:0]];

   // Strict comparison: equal bytes never swap, which keeps the sort stable.
`ifdef UART_SORTER_DESCENDING_EN
   assign do_swap = (cmp_lo < cmp_hi);
`else
   assign do_swap = (cmp_lo > cmp_hi);
`endif

   // Early exit must see a swap made in the final compare of the pass too.
   assign pass_swapped = swapped_q | do_swap;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      j_d       = j_q;
      limit_d   = limit_q;
      swapped_d = swapped_q;
      k_d       = k_q;
      done_d    = 1'b0;
      drop_d    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end

      case (state_q)
         S_FILL: begin
            if (bus.i_Rx_DV) begin
               mem_d[count_q[IDX_W-1:0]] = bus.i_Rx_Byte;
               count_d = count_q + ONE;
               if (count_q == LAST_IDX) begin
                  state_d   = S_SORT;
                  j_d       = '0;
                  limit_d   = LAST_IDX;
                  swapped_d = 1'b0;
               end
            end
         end

         S_SORT: begin
            drop_d = bus.i_Rx_DV;
            if (do_swap) begin
               mem_d[j_q[IDX_W-1:0]]  = cmp_hi;
               mem_d[j_p1[IDX_W-1:0]] = cmp_lo;
            end
            if (j_q < (limit_q - ONE)) begin
               j_d       = j_p1;
               swapped_d = pass_swapped;
            end else if (!pass_swapped || (limit_q == ONE)) begin
               state_d = S_OUT;
               k_d     = '0;
            end else begin
               limit_d   = limit_q - ONE;
               j_d       = '0;
               swapped_d = 1'b0;
            end
         end

         S_OUT: begin
            drop_d = bus.i_Rx_DV;
            if (tx_dv_q && bus.i_Tx_Ready) begin
               if (k_q == LAST_IDX) begin
                  state_d = S_FILL;
                  count_d = '0;
                  k_d     = '0;
                  done_d  = 1'b1;
               end else begin
                  k_d = k_q + ONE;
               end
            end
         end

         default: begin
            state_d = S_FILL;
         end
      endcase

      // Output register is loaded from the next-state view so the first byte
      // is presented on the first S_OUT cycle and each accept advances it in
      // the same step.
      tx_dv_d   = (state_d == S_OUT);
      tx_byte_d = tx_dv_d ? mem_d[k_d[IDX_W-1:0]] : '0;
   end

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_FILL;
         count_q   <= '0;
         j_q       <= '0;
         limit_q   <= '0;
         swapped_q <= 1'b0;
         k_q       <= '0;
         tx_dv_q   <= 1'b0;
         tx_byte_q <= '0;
         done_q    <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         j_q       <= j_d;
         limit_q   <= limit_d;
         swapped_q <= swapped_d;
         k_q       <= k_d;
         tx_dv_q   <= tx_dv_d;
         tx_byte_q <= tx_byte_d;
         done_q    <= done_d;
         drop_q    <= drop_d;
      end
   end

   // Frame buffer: one register per entry so adjacent pairs can swap together.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
         always_ff @(posedge i_clock or negedge i_rst_n) begin
            if (!i_rst_n) begin
               mem_q[gi] <= '0;
            end else begin
               mem_q[gi] <= mem_d[gi];
            end
         end
      end
   endgenerate

   assign bus.o_Tx_DV   = tx_dv_q;
   assign bus.o_Tx_Byte = tx_byte_q;
   assign bus.o_Busy    = (state_q != S_FILL);
   assign bus.o_Done    = done_q;
   assign bus.o_Drop    = drop_q;

endmodule

// File: tb/tb_uart_rx_byte_sorter.sv
`timescale 1ns/1ps
module tb_uart_rx_byte_sorter;
   localparam int DEPTH  = 8;
   localparam int DATA_W = 8;

   typedef logic [DATA_W-1:0] byte_t;
   typedef byte_t bq_t[$];

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_rx_byte_sorter_if #(.DATA_W(DATA_W)) bus ();

   uart_rx_byte_sorter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .i_clock (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   function automatic bit out_of_order(byte_t a, byte_t b);
`ifdef UART_SORTER_DESCENDING_EN
      return a < b;
`else
      return a > b;
`endif
   endfunction

   function automatic bq_t model_sort(bq_t din);
      bq_t d = din;
`ifdef UART_SORTER_DESCENDING_EN
      d.rsort();
`else
      d.sort();
`endif
      return d;
   endfunction

   // Compares needed by a bubble sort with early exit on a swap-free pass.
   function automatic int model_sort_cycles(bq_t din);
      bq_t   a = din;
      int    limit = DEPTH - 1;
      int    cyc = 0;
      bit    sw;
      byte_t t;
      for (int pass = 0; pass < DEPTH; pass++) begin
         sw = 1'b0;
         for (int j = 0; j < limit; j++) begin
            cyc++;
            if (out_of_order(a[j], a[j+1])) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t; sw = 1'b1;
            end
         end
         if (!sw || limit == 1) break;
         limit--;
      end
      return cyc;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic feed_frame(input bq_t d, input int first);
      for (int i = first; i < d.size(); i++) begin
         @(negedge clk);
         bus.i_Rx_DV   = 1'b1;
         bus.i_Rx_Byte = d[i];
         @(posedge clk);
         #1;
         bus.i_Rx_DV   = 1'b0;
         bus.i_Rx_Byte = byte_t'($urandom);
         if (i != d.size() - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic collect(input bit rand_ready, input int inject_at, input int tail,
                          output bq_t got, output int sort_cyc, output int done_cnt,
                          output int drop_cnt, output int dv_span, output bit timeout);
      int cyc = 0;
      int first_dv = -1;
      int last_dv = -1;
      bit done_seen = 1'b0;
      got = {}; sort_cyc = 0; done_cnt = 0; drop_cnt = 0; timeout = 1'b0;
      while (!done_seen) begin
         @(negedge clk);
         bus.i_Rx_DV = 1'b0;
         if (cyc >= 1000) begin timeout = 1'b1; break; end
         if (bus.o_Drop) drop_cnt++;
         if (bus.o_Done) begin done_cnt++; done_seen = 1'b1; end
         if (bus.o_Busy && !bus.o_Tx_DV) begin
            if (sort_cyc == inject_at) begin
               bus.i_Rx_DV = 1'b1; bus.i_Rx_Byte = 8'hAA;
            end
            sort_cyc++;
         end
         bus.i_Tx_Ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (bus.o_Tx_DV) begin
            if (first_dv < 0) first_dv = cyc;
            last_dv = cyc;
            if (bus.i_Tx_Ready) got.push_back(bus.o_Tx_Byte);
         end
         cyc++;
      end
      dv_span = last_dv - first_dv + 1;
      repeat (tail) begin
         @(negedge clk);
         if (bus.o_Done) done_cnt++;
         if (bus.o_Drop) drop_cnt++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bus.i_Rx_DV = 1'b0; bus.i_Rx_Byte = '0; bus.i_Tx_Ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.o_Tx_DV !== 1'b0) begin n_fail++; $display("FAIL reset_tx_dv: got %b expected 0", bus.o_Tx_DV); end
      n_checks++; if (bus.o_Tx_Byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte: got %h expected 00", bus.o_Tx_Byte); end
      n_checks++; if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.o_Busy); end
      n_checks++; if (bus.o_Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.o_Done); end
      n_checks++; if (bus.o_Drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b expected 0", bus.o_Drop); end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", bus.o_Busy); end
      $display("test_reset done");
   endtask

   task automatic run_fixed(input string name, input bq_t d);
      bq_t exp, got; int sc, dc, drc, span; bit to;
      exp = model_sort(d);
      feed_frame(d, 0);
      collect(1'b0, -1, 3, got, sc, dc, drc, span, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: got %b expected 0", name, to); end
      n_checks++; if (sc != model_sort_cycles(d)) begin n_fail++; $display("FAIL %s_sort_cycles: got %0d expected %0d", name, sc, model_sort_cycles(d)); end
      n_checks++; if (got.size() != DEPTH) begin n_fail++; $display("FAIL %s_count: got %0d expected %0d", name, got.size(), DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL %s_byte%0d: got %h expected %h", name, i, got[i], exp[i]); end
      end
      n_checks++; if (span != DEPTH) begin n_fail++; $display("FAIL %s_dv_span: got %0d expected %0d", name, span, DEPTH); end
      n_checks++; if (dc != 1) begin n_fail++; $display("FAIL %s_done_pulses: got %0d expected 1", name, dc); end
      n_checks++; if (drc != 0) begin n_fail++; $display("FAIL %s_drops: got %0d expected 0", name, drc); end
      $display("%s: sort_cycles=%0d bytes=%0d", name, sc, got.size());
   endtask

   task automatic test_reverse();
      bq_t d = {};
      for (int i = 0; i < DEPTH; i++) d.push_back(byte_t'(DEPTH - 1 - i));
      run_fixed("reverse", d);
   endtask

   task automatic test_sorted();
      bq_t d = {};
      for (int i = 0; i < DEPTH; i++) d.push_back(byte_t'(8'h10 + i));
      run_fixed("sorted", d);
   endtask

   task automatic test_duplicates();
      bq_t d = {8'd5, 8'd3, 8'd5, 8'd1, 8'd3, 8'd1, 8'd0, 8'd9};
      run_fixed("dups", d);
   endtask

   task automatic test_ascending_input();
      bq_t d = {};
      for (int i = 0; i < DEPTH; i++) d.push_back(byte_t'(i));
      run_fixed("ascending_in", d);
   endtask

   task automatic test_backpressure();
      bq_t d = {}, exp, got = {};
      int cyc = 0, hold = 0; bit to = 1'b0;
      for (int i = 0; i < DEPTH; i++) d.push_back(byte_t'($urandom));
      exp = model_sort(d);
      feed_frame(d, 0);
      bus.i_Tx_Ready = 1'b1;
      while (!(got.size() == DEPTH && bus.o_Done)) begin
         @(negedge clk);
         if (cyc++ > 500) begin to = 1'b1; break; end
         if (got.size() == 3 && hold < 5) begin
            bus.i_Tx_Ready = 1'b0;
            hold++;
            n_checks++; if (bus.o_Tx_DV !== 1'b1) begin n_fail++; $display("FAIL bp_hold_dv: got %b expected 1", bus.o_Tx_DV); end
            n_checks++; if (bus.o_Tx_Byte !== exp[3]) begin n_fail++; $display("FAIL bp_hold_byte: got %h expected %h", bus.o_Tx_Byte, exp[3]); end
         end else begin
            bus.i_Tx_Ready = 1'b1;
         end
         if (bus.o_Tx_DV && bus.i_Tx_Ready) got.push_back(bus.o_Tx_Byte);
      end
      bus.i_Tx_Ready = 1'b1;
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %b expected 0", to); end
      n_checks++; if (got.size() != DEPTH) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", got.size(), DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL bp_byte%0d: got %h expected %h", i, got[i], exp[i]); end
      end
      $display("backpressure: held %0d cycles bytes=%0d", hold, got.size());
   endtask

   task automatic test_drop_and_reset();
      bq_t d = {}, exp, got; int sc, dc, drc, span, cyc; bit to;
      for (int i = 0; i < DEPTH; i++) d.push_back(byte_t'($urandom_range(0, 127)));
      exp = model_sort(d);
      feed_frame(d, 0);
      collect(1'b0, 3, 3, got, sc, dc, drc, span, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL drop_timeout: got %b expected 0", to); end
      n_checks++; if (drc != 1) begin n_fail++; $display("FAIL drop_pulses: got %0d expected 1", drc); end
      n_checks++; if (got.size() != DEPTH) begin n_fail++; $display("FAIL drop_count: got %0d expected %0d", got.size(), DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL drop_byte%0d: got %h expected %h", i, got[i], exp[i]); end
      end
      $display("drop: drops=%0d bytes=%0d", drc, got.size());

      // Abort a frame mid-output with reset.
      d = {};
      for (int i = 0; i < DEPTH; i++) d.push_back(byte_t'($urandom));
      feed_frame(d, 0);
      cyc = 0; to = 1'b0;
      bus.i_Tx_Ready = 1'b1;
      do begin
         @(negedge clk);
         if (cyc++ > 200) begin to = 1'b1; break; end
      end while (!bus.o_Tx_DV);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rst_wait_dv_timeout: got %b expected 0", to); end
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.o_Tx_DV !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_dv: got %b expected 0", bus.o_Tx_DV); end
      n_checks++; if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_busy: got %b expected 0", bus.o_Busy); end
      @(negedge clk);
      rst_n = 1'b1;
      run_fixed("after_reset", d);
   endtask

   task automatic test_back_to_back();
      bq_t a = {}, b = {}, exp, got; int sc, dc, drc, span; bit to;
      for (int i = 0; i < DEPTH; i++) begin
         a.push_back(byte_t'($urandom));
         b.push_back(byte_t'($urandom));
      end
      feed_frame(a, 0);
      collect(1'b0, -1, 0, got, sc, dc, drc, span, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_a_timeout: got %b expected 0", to); end
      // Still in the o_Done cycle: this byte must open the next frame.
      bus.i_Rx_DV = 1'b1; bus.i_Rx_Byte = b[0];
      @(posedge clk);
      #1;
      bus.i_Rx_DV = 1'b0;
      feed_frame(b, 1);
      exp = model_sort(b);
      collect(1'b0, -1, 2, got, sc, dc, drc, span, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: got %b expected 0", to); end
      n_checks++; if (drc != 0) begin n_fail++; $display("FAIL b2b_drops: got %0d expected 0", drc); end
      n_checks++; if (got.size() != DEPTH) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", got.size(), DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got[i], exp[i]); end
      end
      $display("back_to_back: bytes=%0d", got.size());
   endtask

   task automatic test_random();
      bq_t d, exp, got; int sc, dc, drc, span; bit to;
      for (int f = 0; f < 6; f++) begin
         d = {};
         for (int i = 0; i < DEPTH; i++) d.push_back(byte_t'($urandom_range(0, 15) * 13));
         exp = model_sort(d);
         feed_frame(d, 0);
         collect(1'b1, -1, 2, got, sc, dc, drc, span, to);
         n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout: got %b expected 0", f, to); end
         n_checks++; if (sc != model_sort_cycles(d)) begin n_fail++; $display("FAIL rand%0d_sort_cycles: got %0d expected %0d", f, sc, model_sort_cycles(d)); end
         n_checks++; if (dc != 1) begin n_fail++; $display("FAIL rand%0d_done_pulses: got %0d expected 1", f, dc); end
         n_checks++; if (got.size() != DEPTH) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", f, got.size(), DEPTH); end
         for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h expected %h", f, i, got[i], exp[i]); end
         end
         $display("random frame %0d: sort_cycles=%0d bytes=%0d", f, sc, got.size());
      end
   endtask

   initial begin
      test_reset();
      test_reverse();
      test_sorted();
      test_duplicates();
      test_ascending_input();
      test_backpressure();
      test_drop_and_reset();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
